// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-digit slots with a leading blank phase,
// frame-boundary snapshots of the display data and per-digit blinking.
module display_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 200000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned BLINK_FRAMES = 62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CntW = $clog2(TICK_DIV + 1);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(TICK_DIV);
  localparam logic [CntW-1:0] BlankMax = CntW'(BLANK_CYCLES);
  localparam logic [FrmW-1:0] FrmMax   = FrmW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            blink_q, blink_d;
  logic [15:0]     dig_q, dig_d;
  logic [3:0]      dpsh_q, dpsh_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            fs_q, fs_d;

  logic            drive;
  logic [3:0]      cur_dig;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    blink_d = blink_q;
    dig_d   = dig_q;
    dpsh_d  = dpsh_q;
    mask_d  = mask_q;
    fs_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          dig_d   = digits_in;
          dpsh_d  = dp_in;
          mask_d  = blink_mask;
          fs_d    = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          // Disable beats a coincident frame wrap: no snapshot, no pulse.
          state_d = StIdle;
          cnt_d   = CntW'(1);
          idx_d   = 2'd3;
          frm_d   = '0;
          blink_d = 1'b0;
        end else if (cnt_q == CntMax) begin
          cnt_d = CntW'(1);
          idx_d = idx_q - 2'd1;
          if (idx_q == 2'd0) begin
            dig_d  = digits_in;
            dpsh_d = dp_in;
            mask_d = blink_mask;
            fs_d   = 1'b1;
            if (frm_q == FrmMax) begin
              frm_d   = '0;
              blink_d = ~blink_q;
            end else begin
              frm_d = frm_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are a registered function of the current state, so they lag it by one cycle.
  assign drive   = (state_q == StRun) && (cnt_q > BlankMax);
  assign cur_dig = dig_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_d = 4'hF;
    if (drive && !(blink_q && mask_q[idx_q])) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = (state_q == StRun) ? bcd_to_seg(cur_dig) : 7'h7F;
    dp_d  = drive ? ~dpsh_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= CntW'(1);
      idx_q   <= 2'd3;
      frm_q   <= '0;
      blink_q <= 1'b0;
      dig_q   <= 16'hFFFF;
      dpsh_q  <= 4'h0;
      mask_q  <= 4'h0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      dig_q   <= dig_d;
      dpsh_q  <= dpsh_d;
      mask_q  <= mask_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
